// File: rtl/fb_write_scheduler_pkg.sv
// Shared types and constants for the framebuffer write scheduler.
package fb_pkg;
  localparam int FB_WORDS      = 9600;
  localparam int FB_HALF_BIT   = 14;
  localparam int FB_STARVE_MAX = 8;

  typedef logic [14:0] fb_addr_t;
  typedef logic [31:0] fb_word_t;

  typedef enum logic {IDLE, CLEAR} clr_state_t;
endpackage

// File: rtl/fb_write_scheduler_if.sv
// Avalon host write bus into the framebuffer write scheduler.
interface fb_write_scheduler_if;
  import fb_pkg::*;
  logic     chipselect;
  logic     write;
  fb_addr_t address;
  fb_word_t writedata;
  logic     waitrequest;

  modport master (output chipselect, write, address, writedata, input waitrequest);
  modport slave  (input chipselect, write, address, writedata, output waitrequest);
endinterface

// File: rtl/fb_write_scheduler_clear_engine.sv
// Back-buffer clear sweep: fill latch, word pointer, IDLE/CLEAR FSM and done pulse.
module fb_clear_engine import fb_pkg::*; #(
  parameter int WORDS = FB_WORDS,
  parameter int PTR_W = FB_HALF_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_req,
  input  fb_word_t         fill_pattern,
  input  logic             clr_grant,
  output logic             clear_busy,
  output logic [PTR_W-1:0] clr_ptr,
  output fb_word_t         fill,
  output logic             clear_done
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(WORDS - 1);

  clr_state_t       state, state_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  fb_word_t         fill_nxt;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clr_ptr    <= '0;
      fill       <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_ptr    <= ptr_nxt;
      fill       <= fill_nxt;
      clear_done <= done_nxt;
    end
  end

  // Pointer only moves on a won slot; it parks on the last word when the sweep ends.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    fill_nxt  = fill;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (clear_req) begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
        fill_nxt  = fill_pattern;
      end
      CLEAR: if (clr_grant) begin
        if (clr_ptr == LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          ptr_nxt = clr_ptr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clear_busy = (state == CLEAR);
endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port arbiter: Avalon host vs. clear engine, plus frame-synchronous double-buffer swap.
module fb_write_scheduler import fb_pkg::*; #(
  parameter int WORDS      = FB_WORDS,
  parameter int STARVE_MAX = FB_STARVE_MAX,
  parameter int HALF_BIT   = FB_HALF_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  fb_write_scheduler_if.slave  avs,
  input  logic                 clear_req,
  input  fb_word_t             fill_pattern,
  input  logic                 swap_req,
  input  logic                 frame_start,
  output logic                 fb_wren,
  output fb_addr_t             fb_wraddress,
  output fb_word_t             fb_data,
  output logic                 front_buf,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic                 swap_done
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                hreq, host_grant, clr_grant, back, commit, swap_pending;
  logic [SW-1:0]       starve_cnt;
  logic [HALF_BIT-1:0] clr_ptr;
  fb_word_t            fill;
  fb_addr_t            host_addr, clr_addr;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^avs.address[$bits(fb_addr_t)-1:HALF_BIT];

  assign hreq            = avs.chipselect & avs.write;
  assign host_grant      = hreq & (~clear_busy | (starve_cnt < SW'(STARVE_MAX)));
  assign clr_grant       = clear_busy & ~host_grant;
  assign avs.waitrequest = hreq & ~host_grant;

  // back uses the registered front_buf, so a write in a commit cycle lands in the old back half.
  assign back   = ~front_buf;
  assign commit = frame_start & swap_pending & ~clear_busy;

  always_comb begin
    host_addr                 = '0;
    host_addr[HALF_BIT-1:0]   = avs.address[HALF_BIT-1:0];
    host_addr[HALF_BIT]       = back;
    clr_addr                  = '0;
    clr_addr[HALF_BIT-1:0]    = clr_ptr;
    clr_addr[HALF_BIT]        = back;
  end

  fb_clear_engine #(.WORDS(WORDS), .PTR_W(HALF_BIT)) u_clr (
    .clk         (clk),
    .reset       (reset),
    .clear_req   (clear_req),
    .fill_pattern(fill_pattern),
    .clr_grant   (clr_grant),
    .clear_busy  (clear_busy),
    .clr_ptr     (clr_ptr),
    .fill        (fill),
    .clear_done  (clear_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_wren      <= 1'b0;
      fb_wraddress <= '0;
      fb_data      <= '0;
      starve_cnt   <= '0;
      front_buf    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      fb_wren <= host_grant | clr_grant;
      if (host_grant) begin
        fb_wraddress <= host_addr;
        fb_data      <= avs.writedata;
      end else if (clr_grant) begin
        fb_wraddress <= clr_addr;
        fb_data      <= fill;
      end
      // Streak of host wins only matters while a sweep is waiting for slots.
      if (clear_busy && host_grant) starve_cnt <= starve_cnt + 1'b1;
      else                          starve_cnt <= '0;
      swap_done <= commit;
      if (commit) begin
        front_buf    <= ~front_buf;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end
endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sequences all writes into the 1-bpp display framebuffer RAM (32K x 32-bit, single write port).
- Shares the write port between two requesters:
  - the Avalon host;
  - an internal clear/fill engine that sweeps the back buffer.
- Implements double buffering: two 16K-word halves, with the front/back swap committed only at frame start so the scanout never tears.
- Sits between the Avalon slave interface and the display's framebuffer write port; its front_buf output selects the scanout read half.

Parameters:
- WORDS, 9600, words per frame (640x480/32); clear sweep length.
- STARVE_MAX, 8, consecutive host grants allowed while a clear is pending before the clear engine is forced one slot.
- HALF_BIT, 14, address bit that selects the buffer half.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  Avalon host select
- write  in  1  Avalon host write strobe
- address  in  15  host word address; bit 14 ignored, bits 13:0 map into the back buffer
- writedata  in  32  host write data
- waitrequest  out  1  host must hold its request; combinational
- clear_req  in  1  one-cycle pulse: fill the back buffer with fill_pattern
- fill_pattern  in  32  value sampled on an accepted clear_req
- swap_req  in  1  one-cycle pulse: exchange front and back at the next frame start
- frame_start  in  1  one-cycle pulse at the first active line (vcount==0, hcount==0)
- fb_wren  out  1  framebuffer write enable (registered)
- fb_wraddress  out  15  framebuffer write address (registered)
- fb_data  out  32  framebuffer write data (registered)
- front_buf  out  1  half currently scanned out
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse after the last clear word is issued
- swap_done  out  1  one-cycle pulse in the cycle front_buf changes

Behaviour:
- Reset values:
  - fb_wren=0, fb_wraddress=0, fb_data=0;
  - front_buf=0, clear_busy=0, clear_done=0, swap_done=0;
  - FSM in IDLE, swap_pending=0, starve_cnt=0, clr_ptr=0.
- Reset mid-sweep aborts the sweep; no further writes are issued.
- Back buffer: back = ~front_buf. Physical address = {back, addr[13:0]}.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clear_req. In the same cycle: latch fill_pattern, set clr_ptr=0, set clear_busy=1.
  - clear_req while already in CLEAR is ignored.
- Host request: hreq = chipselect & write.
- Arbitration, evaluated each cycle:
  - In IDLE the host is always granted.
  - In CLEAR:
    - host wins if hreq & starve_cnt<STARVE_MAX; starve_cnt increments;
    - otherwise the clear engine wins; starve_cnt resets to 0.
- waitrequest = hreq & ~host_grant.
  - The host holds its address and data until waitrequest is low.
  - The write is accepted in the cycle waitrequest=0.
- Output latency: a granted write appears on fb_wren/fb_wraddress/fb_data on the next clock edge (1-cycle latency). fb_wren=0 when no one is granted.
- Clear sweep:
  - each clear grant writes fill_pattern to {back, clr_ptr} and increments clr_ptr;
  - on the grant with clr_ptr==WORDS-1: next cycle CLEAR->IDLE, clear_busy=0, clear_done=1 for one cycle;
  - the clear_done edge coincides with the last fb_wren.
  - clr_ptr is 14 bits and never exceeds WORDS-1.
- Swap:
  - swap_req sets swap_pending; a repeated swap_req while pending is absorbed (single swap).
  - Commit when frame_start & swap_pending & state==IDLE: front_buf toggles on that edge, swap_done pulses, swap_pending clears.
  - If frame_start arrives while in CLEAR, the swap waits for the next frame_start after the sweep ends.
  - A clear never targets the buffer being scanned out, because back is fixed for the whole sweep.
- Host write in the same cycle as a swap commit: back is evaluated pre-toggle (the registered front_buf value), so the write lands in the old back half.
- Simultaneous events:
  - clear_req and swap_req in the same cycle: both are latched. The swap waits for the clear to finish.
  - swap_req and frame_start in the same cycle: no commit that frame (pending is set at the edge).

Decomposition:
- Shared package fb_pkg holds:
  - typedef fb_addr_t (15 bits), fb_word_t (32 bits);
  - constants FB_WORDS=9600, FB_HALF_BIT=14;
  - enum clr_state_t {IDLE, CLEAR}.
- One sub-module, fb_clear_engine: holds the clr_ptr counter, the fill register, the FSM, and the clear_done pulse.
- Arbitration, the swap logic and the output registers stay in the top.

Test Plan:
- Reset, then host write addr=0x0005 data=0xA5A5A5A5 -> next cycle fb_wren=1, fb_wraddress=0x4005 (back=1), fb_data=0xA5A5A5A5, waitrequest=0 throughout.
- clear_req with fill=0xFFFFFFFF and no host traffic -> 9600 consecutive fb_wren cycles, addresses 0x4000..0x657F; clear_done one cycle after the final clear grant; clear_busy low afterward.
- Clear running plus continuous host writes -> pattern of 8 host grants then 1 clear grant (waitrequest high in that cycle); all 9600 clear words still written; no host write lost.
- swap_req, then frame_start 100 cycles later in IDLE -> front_buf 0->1 and swap_done pulse on that edge; subsequent host addr=0x0000 maps to fb_wraddress=0x0000.
- swap_req during a clear; frame_start mid-sweep, then another after clear_done -> front_buf unchanged at the first, toggles at the second.
- Assert reset in the middle of a sweep -> next cycle fb_wren=0, clear_busy=0, front_buf=0; a new clear_req restarts from clr_ptr=0.
